// File: rtl/keccak_arb_pkg.sv
// ---------------------------------------------------------------------------
// keccak_arb_pkg
// Shared types and constants for the Keccak core arbiter.
//   arb_state_t  : arbiter FSM states
//   MODE_*       : Keccak mode encodings driven on core_mode
//   KECCAK_DW    : default data word width
// ---------------------------------------------------------------------------
package keccak_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ABSORB,
      ST_SQUEEZE,
      ST_RELEASE
   } arb_state_t;

   localparam logic [1:0] MODE_SHA3_256 = 2'b00;
   localparam logic [1:0] MODE_SHA3_512 = 2'b01;
   localparam logic [1:0] MODE_SHAKE128 = 2'b10;
   localparam logic [1:0] MODE_SHAKE256 = 2'b11;

   localparam int KECCAK_DW = 32;

endpackage

// File: rtl/keccak_rr_pick.sv
// ---------------------------------------------------------------------------
// keccak_rr_pick
// Combinational round-robin winner selection.
//   req     in  NUM_REQ : request vector
//   ptr     in  PW      : round-robin pointer (index with highest priority)
//   win     out NUM_REQ : one-hot winner (all zero when no request)
//   win_idx out PW      : index of the winner
// Build option: KECCAK_ARB_PRIO_EN gives requester 0 absolute priority; the
// remaining requesters keep rotating among themselves.
// ---------------------------------------------------------------------------
module keccak_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [PW-1:0]      win_idx
);

   logic               found;
   logic [NUM_REQ-1:0] rr_req;
   int                 idx;

   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      rr_req  = req;
      idx     = 0;
`ifdef KECCAK_ARB_PRIO_EN
      // Requester 0 pre-empts the rotation; mask it out of the RR search so
      // the others only rotate among themselves.
      if (req[0]) begin
         win[0] = 1'b1;
         found  = 1'b1;
      end
      rr_req[0] = 1'b0;
`endif
      // Scan from the pointer upward, wrapping to 0. ptr < NUM_REQ, so a
      // single subtraction is enough for the wrap.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && rr_req[idx]) begin
            found        = 1'b1;
            win[idx]     = 1'b1;
            win_idx      = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/keccak_arbiter.sv
// ---------------------------------------------------------------------------
// keccak_arbiter
// Shares one Keccak core between NUM_REQ requesters. A requester is granted
// the core for a whole job (first absorbed word through last squeezed word);
// its mode is latched onto core_mode and its streams are steered to/from the
// core with purely combinational handshakes.
//
// Ports
//   clk, rst                 : clock, async active-high reset
//   req, req_mode            : per-requester job request and 2-bit mode
//   gnt, busy                : registered one-hot grant, FSM not idle
//   in_data/valid/last/ready : per-requester input streams
//   out_data/valid/last/ready: output stream (data broadcast, valid per req)
//   core_*                   : Keccak core src/dst handshakes and mode
//
// Build option: KECCAK_ARB_PRIO_EN (see keccak_rr_pick) gives requester 0
// absolute priority at arbitration time.
// ---------------------------------------------------------------------------
module keccak_arbiter
   import keccak_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DW      = KECCAK_DW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [2*NUM_REQ-1:0]    req_mode,
   output logic [NUM_REQ-1:0]      gnt,
   output logic                    busy,
   input  logic [DW*NUM_REQ-1:0]   in_data,
   input  logic [NUM_REQ-1:0]      in_valid,
   input  logic [NUM_REQ-1:0]      in_last,
   output logic [NUM_REQ-1:0]      in_ready,
   output logic [DW-1:0]           out_data,
   output logic [NUM_REQ-1:0]      out_valid,
   output logic                    out_last,
   input  logic [NUM_REQ-1:0]      out_ready,
   output logic [1:0]              core_mode,
   output logic [DW-1:0]           core_din,
   output logic                    core_src_ready,
   input  logic                    core_src_read,
   input  logic [DW-1:0]           core_dout,
   output logic                    core_dst_ready,
   input  logic                    core_dst_write,
   input  logic                    core_last_out_word
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t                 state;
   logic [PW-1:0]              ptr;
   logic [PW-1:0]              gidx;
   logic [PW-1:0]              win_idx;
   logic [NUM_REQ-1:0]         win;
   logic [NUM_REQ-1:0][DW-1:0] in_words;
   logic [NUM_REQ-1:0][1:0]    modes;
   logic                       absorb_done;
   logic                       squeeze_done;

   assign in_words = in_data;
   assign modes    = req_mode;

   keccak_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win     (win),
      .win_idx (win_idx)
   );

   assign absorb_done  = in_valid[gidx] & in_last[gidx] & core_src_read;
   assign squeeze_done = core_dst_write & core_last_out_word;
   assign busy         = (state != ST_IDLE);

   // Arbitration FSM. gnt and core_mode are registered; req is only looked
   // at in IDLE, so a requester dropping req mid-job has no effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         gidx      <= '0;
         gnt       <= '0;
         core_mode <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  gnt       <= win;
                  gidx      <= win_idx;
                  core_mode <= modes[win_idx];
                  state     <= ST_SETUP;
               end
            end
            // One dead cycle so the core sees core_mode settled before data.
            ST_SETUP:   state <= ST_ABSORB;
            ST_ABSORB:  if (absorb_done)  state <= ST_SQUEEZE;
            ST_SQUEEZE: if (squeeze_done) state <= ST_RELEASE;
            ST_RELEASE: begin
               gnt   <= '0;
               ptr   <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Stream steering: zero-latency pass-through for the granted requester,
   // everything else held at 0.
   always_comb begin
      in_ready       = '0;
      core_din       = '0;
      core_src_ready = 1'b0;
      out_data       = '0;
      out_valid      = '0;
      out_last       = 1'b0;
      core_dst_ready = 1'b0;
      case (state)
         ST_ABSORB: begin
            core_din       = in_words[gidx];
            core_src_ready = in_valid[gidx];
            in_ready[gidx] = core_src_read;
         end
         ST_SQUEEZE: begin
            out_data        = core_dout;
            core_dst_ready  = out_ready[gidx];
            out_valid[gidx] = core_dst_write;
            out_last        = squeeze_done;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/keccak_arbiter.md
# keccak_arbiter

Shares the single Keccak core (SHA3/SHAKE engine with its `src_ready`/`src_read` input handshake and `dst_ready`/`dst_write` output handshake) between several Dilithium requesters such as ExpandA, ExpandS, SampleInBall and the message/commitment hash. It grants the core to one requester at a time, latches that requester's mode, and steers its input word stream into the core. It steers the core's output stream back to the same requester. The grant is held for one complete hash job, from the first absorbed word through the last squeezed word.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DW`, 32: word width of the data streams.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: per-requester job request.
- `req_mode` in 2*NUM_REQ: per-requester Keccak mode; slice i is `[2i+1:2i]`.
- `gnt` out NUM_REQ: one-hot grant, held for the whole job.
- `busy` out 1: high whenever the state is not IDLE.
- `in_data` in DW*NUM_REQ: per-requester input words; the first word is the length header.
- `in_valid` in NUM_REQ: per-requester input word valid.
- `in_last` in NUM_REQ: marks the final input word of the job.
- `in_ready` out NUM_REQ: input word accepted this cycle.
- `out_data` out DW: core output, broadcast to all requesters.
- `out_valid` out NUM_REQ: output word valid, granted requester only.
- `out_last` out 1: final output word of the job.
- `out_ready` in NUM_REQ: requester can accept an output word.
- `core_mode` out 2: mode presented to the core.
- `core_din` out DW: word presented to the core.
- `core_src_ready` out 1: core input has a word available.
- `core_src_read` in 1: core consumes the presented word.
- `core_dout` in DW: core output word.
- `core_dst_ready` out 1: sink can accept a core output word.
- `core_dst_write` in 1: core writes an output word.
- `core_last_out_word` in 1: the current core write is the last of the job.

## Operation
- FSM states are IDLE, SETUP, ABSORB, SQUEEZE and RELEASE.
- **IDLE:** if any `req` bit is high, the winner g is chosen by the pick logic. Next state is SETUP with `gnt[g]` set and `req_mode` slice g latched into `core_mode`.
- **SETUP:** lasts exactly one cycle so the core sees a stable mode before data arrives. Next state is ABSORB.
- **ABSORB:**
  - `core_din` = `in_data` slice g; `core_src_ready` = `in_valid[g]`.
  - `in_ready[g]` = `core_src_read`, combinational pass-through. All other `in_ready` bits are 0.
  - The state moves to SQUEEZE when `in_valid[g] & in_last[g] & core_src_read` are all high in the same cycle.
- **SQUEEZE:**
  - `out_data` = `core_dout`; `core_dst_ready` = `out_ready[g]`.
  - `out_valid[g]` = `core_dst_write`; `out_last` = `core_dst_write & core_last_out_word`.
  - The state moves to RELEASE on `core_dst_write & core_last_out_word`.
- **RELEASE:**
  - Lasts one cycle. `gnt` is cleared and the round-robin pointer is set to g+1 mod NUM_REQ.
  - Next state is always IDLE. A new grant therefore cannot appear earlier than 2 cycles after `out_last`.
- **Pick rule:** the lowest-index requesting bit at or above the pointer wins, wrapping around to index 0.
- Dropping `req[g]` after the grant is ignored; the job runs to completion. `req` is only sampled in IDLE.
- `in_last` on a non-granted requester is ignored. Words from non-granted requesters are never accepted.
- `core_mode` is held from SETUP until the next grant.

## Timing
- **Reset values:** state IDLE, pointer 0, `gnt`=0, `busy`=0, `core_mode`=0. All ready/valid/last outputs are 0; `out_data` and `core_din` are 0.
- `gnt` and `core_mode` are registered. The stream handshakes are combinational, with zero added latency.
- **Grant latency:** `req` high in IDLE produces `gnt` on the next edge, and ABSORB starts one cycle later.
- If `rst` asserts mid-job, everything returns to reset values immediately. The requester must restart its job.
- A single-word job (header word only, with `in_last` set) is legal: ABSORB lasts one transfer.

## Configuration
- **`KECCAK_ARB_PRIO_EN` defined:** requester 0 wins any IDLE arbitration in which `req[0]` is high, regardless of the pointer. Requesters 1..NUM_REQ-1 remain round-robin among themselves. Intended for the latency-critical SampleInBall path.
- **`KECCAK_ARB_PRIO_EN` undefined:** pure round-robin across all requesters.

## Structure
- **`keccak_arb_pkg`** holds:
  - the state enum (IDLE, SETUP, ABSORB, SQUEEZE, RELEASE);
  - the mode constants MODE_SHA3_256, MODE_SHA3_512, MODE_SHAKE128, MODE_SHAKE256;
  - the `DW` default.
- **Sub-module `keccak_rr_pick`:** combinational. Inputs are `req` and the pointer; outputs are the one-hot winner and its index. The priority override under the macro lives inside this sub-module.

## Test plan
- **Single job:** `req`=0010 with SHAKE128. Check that `gnt`=0010 appears 1 cycle later and `core_mode`=2'b10. Send 5 words with `in_last` on the 5th, then have the core emit 8 words. Check that `out_valid[1]` pulses 8 times, `out_last` is high on the 8th, and `gnt`=0 two cycles later.
- **Round-robin:** hold `req`=1111 constantly. The grant order must be 0,1,2,3,0. With `KECCAK_ARB_PRIO_EN` defined, the order must be 0,0,0,….
- **Backpressure:** during SQUEEZE, toggle `out_ready[g]` every other cycle. Check that `core_dst_ready` mirrors it and that no word is lost or duplicated (compare against the scoreboard).
- **Request drop:** drop `req[2]` during ABSORB of requester 2. The job must still complete, and `gnt[2]` is held until RELEASE.
- **Isolation:** requester 3 drives `in_valid`/`in_last` while requester 1 holds the grant. `in_ready[3]` must stay 0 and the core must receive only requester 1's data.
- **Reset mid-job:** assert `rst` in SQUEEZE. All outputs must go to 0 asynchronously, and the next grant after reset is to requester 0.
